axi_arbiter_2m: RTL

AXI_ARBITER_2M -- requirements
Module: axi_arbiter_2m

---
 rtl/axi_arb_pkg.sv | 18 +
 rtl/rr_arb2.sv | 31 +++
 rtl/axi_arbiter_2m.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the two-master AXI arbiter.
package axi_arb_pkg;

  localparam int ID_W   = 4;
  localparam int IDS_W  = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;
  localparam int SIZE_W = 3;
  localparam int STRB_W = 4;

  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

  typedef enum logic [1:0] {RD_IDLE, RD_ADDR, RD_DATA} rd_state_t;
  typedef enum logic [1:0] {WR_IDLE, WR_ADDR, WR_DATA, WR_RESP} wr_state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer remembers the most recent winner.
module rr_arb2
  import axi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_idx,
  output logic [1:0] grant
);

  logic last_q;

  // Reset to M1 as "last winner" so M0 wins the first contested request.
  always_ff @(posedge clk) begin
    if (rst)      last_q <= MST_M1;
    else if (upd) last_q <= upd_idx;
  end

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (last_q == MST_M0) ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/axi_arbiter_2m.sv
// Two-master to one-slave AXI arbiter with independent read and write FSMs.
//   state   | meaning
//   RD_IDLE | combinational AR grant, no read outstanding
//   RD_ADDR | owner latched, S_ARVALID held until accepted
//   RD_DATA | R beats routed to owner until RLAST
//   WR_IDLE | combinational AW grant, no write outstanding
//   WR_ADDR | owner latched, S_AWVALID held until accepted
//   WR_DATA | owner's W beats forwarded until WLAST
//   WR_RESP | B routed to owner
module axi_arbiter_2m
  import axi_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ID_W-1:0]   M0_ARID,   input logic [ID_W-1:0]   M1_ARID,
  input  logic [ADDR_W-1:0] M0_ARADDR, input logic [ADDR_W-1:0] M1_ARADDR,
  input  logic [LEN_W-1:0]  M0_ARLEN,  input logic [LEN_W-1:0]  M1_ARLEN,
  input  logic [SIZE_W-1:0] M0_ARSIZE, input logic [SIZE_W-1:0] M1_ARSIZE,
  input  logic [1:0]        M0_ARBURST, input logic [1:0]       M1_ARBURST,
  input  logic              M0_ARVALID, input logic             M1_ARVALID,
  output logic              M0_ARREADY, output logic            M1_ARREADY,
  output logic [ID_W-1:0]   M0_RID,    output logic [ID_W-1:0]   M1_RID,
  output logic [DATA_W-1:0] M0_RDATA,  output logic [DATA_W-1:0] M1_RDATA,
  output logic [1:0]        M0_RRESP,  output logic [1:0]        M1_RRESP,
  output logic              M0_RLAST,  output logic              M1_RLAST,
  output logic              M0_RVALID, output logic              M1_RVALID,
  input  logic              M0_RREADY, input  logic              M1_RREADY,
  input  logic [ID_W-1:0]   M0_AWID,   input logic [ID_W-1:0]   M1_AWID,
  input  logic [ADDR_W-1:0] M0_AWADDR, input logic [ADDR_W-1:0] M1_AWADDR,
  input  logic [LEN_W-1:0]  M0_AWLEN,  input logic [LEN_W-1:0]  M1_AWLEN,
  input  logic [SIZE_W-1:0] M0_AWSIZE, input logic [SIZE_W-1:0] M1_AWSIZE,
  input  logic [1:0]        M0_AWBURST, input logic [1:0]       M1_AWBURST,
  input  logic              M0_AWVALID, input logic             M1_AWVALID,
  output logic              M0_AWREADY, output logic            M1_AWREADY,
  input  logic [DATA_W-1:0] M0_WDATA,  input logic [DATA_W-1:0] M1_WDATA,
  input  logic [STRB_W-1:0] M0_WSTRB,  input logic [STRB_W-1:0] M1_WSTRB,
  input  logic              M0_WLAST,  input logic              M1_WLAST,
  input  logic              M0_WVALID, input logic              M1_WVALID,
  output logic              M0_WREADY, output logic             M1_WREADY,
  output logic [ID_W-1:0]   M0_BID,    output logic [ID_W-1:0]   M1_BID,
  output logic [1:0]        M0_BRESP,  output logic [1:0]        M1_BRESP,
  output logic              M0_BVALID, output logic              M1_BVALID,
  input  logic              M0_BREADY, input  logic              M1_BREADY,
  output logic [IDS_W-1:0]  S_ARID,
  output logic [ADDR_W-1:0] S_ARADDR,
  output logic [LEN_W-1:0]  S_ARLEN,
  output logic [SIZE_W-1:0] S_ARSIZE,
  output logic [1:0]        S_ARBURST,
  output logic              S_ARVALID,
  input  logic              S_ARREADY,
  input  logic [IDS_W-1:0]  S_RID,
  input  logic [DATA_W-1:0] S_RDATA,
  input  logic [1:0]        S_RRESP,
  input  logic              S_RLAST,
  input  logic              S_RVALID,
  output logic              S_RREADY,
  output logic [IDS_W-1:0]  S_AWID,
  output logic [ADDR_W-1:0] S_AWADDR,
  output logic [LEN_W-1:0]  S_AWLEN,
  output logic [SIZE_W-1:0] S_AWSIZE,
  output logic [1:0]        S_AWBURST,
  output logic              S_AWVALID,
  input  logic              S_AWREADY,
  output logic [DATA_W-1:0] S_WDATA,
  output logic [STRB_W-1:0] S_WSTRB,
  output logic              S_WLAST,
  output logic              S_WVALID,
  input  logic              S_WREADY,
  input  logic [IDS_W-1:0]  S_BID,
  input  logic [1:0]        S_BRESP,
  input  logic              S_BVALID,
  output logic              S_BREADY
);

  rd_state_t  rd_state, rd_next;
  wr_state_t  wr_state, wr_next;
  logic       rd_owner, wr_owner, rd_latch, wr_latch, rd_upd, wr_upd;
  logic       ar_src, aw_src;
  logic [1:0] rd_gnt, wr_gnt;
  logic       unused_id_hi;

  rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .req({M1_ARVALID, M0_ARVALID}),
                    .upd(rd_upd), .upd_idx(rd_owner), .grant(rd_gnt));
  rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .req({M1_AWVALID, M0_AWVALID}),
                    .upd(wr_upd), .upd_idx(wr_owner), .grant(wr_gnt));

  assign S_ARID    = {(IDS_W-ID_W)'(ar_src), ar_src ? M1_ARID : M0_ARID};
  assign S_ARADDR  = ar_src ? M1_ARADDR  : M0_ARADDR;
  assign S_ARLEN   = ar_src ? M1_ARLEN   : M0_ARLEN;
  assign S_ARSIZE  = ar_src ? M1_ARSIZE  : M0_ARSIZE;
  assign S_ARBURST = ar_src ? M1_ARBURST : M0_ARBURST;
  assign S_AWID    = {(IDS_W-ID_W)'(aw_src), aw_src ? M1_AWID : M0_AWID};
  assign S_AWADDR  = aw_src ? M1_AWADDR  : M0_AWADDR;
  assign S_AWLEN   = aw_src ? M1_AWLEN   : M0_AWLEN;
  assign S_AWSIZE  = aw_src ? M1_AWSIZE  : M0_AWSIZE;
  assign S_AWBURST = aw_src ? M1_AWBURST : M0_AWBURST;
  assign S_WDATA   = wr_owner ? M1_WDATA : M0_WDATA;
  assign S_WSTRB   = wr_owner ? M1_WSTRB : M0_WSTRB;
  assign S_WLAST   = wr_owner ? M1_WLAST : M0_WLAST;

  // Payloads are broadcast; only the VALIDs select the receiving master.
  assign M0_RID   = S_RID[ID_W-1:0];  assign M1_RID   = S_RID[ID_W-1:0];
  assign M0_RDATA = S_RDATA;          assign M1_RDATA = S_RDATA;
  assign M0_RRESP = S_RRESP;          assign M1_RRESP = S_RRESP;
  assign M0_RLAST = S_RLAST;          assign M1_RLAST = S_RLAST;
  assign M0_BID   = S_BID[ID_W-1:0];  assign M1_BID   = S_BID[ID_W-1:0];
  assign M0_BRESP = S_BRESP;          assign M1_BRESP = S_BRESP;
  assign unused_id_hi = ^{S_RID[IDS_W-1:ID_W], S_BID[IDS_W-1:ID_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      wr_state <= WR_IDLE;
      rd_owner <= MST_M0;
      wr_owner <= MST_M0;
    end else begin
      rd_state <= rd_next;
      wr_state <= wr_next;
      if (rd_latch) rd_owner <= rd_gnt[1];
      if (wr_latch) wr_owner <= wr_gnt[1];
    end
  end

  always_comb begin
    rd_next = rd_state;  rd_latch = 1'b0;  rd_upd = 1'b0;  ar_src = rd_owner;
    S_ARVALID = 1'b0;  M0_ARREADY = 1'b0;  M1_ARREADY = 1'b0;
    S_RREADY  = 1'b0;  M0_RVALID  = 1'b0;  M1_RVALID  = 1'b0;
    if (!rst) begin
      case (rd_state)
        RD_IDLE: begin
          ar_src = rd_gnt[1];
          if (|rd_gnt) begin
            S_ARVALID  = 1'b1;
            M0_ARREADY = rd_gnt[0] & S_ARREADY;
            M1_ARREADY = rd_gnt[1] & S_ARREADY;
            rd_latch   = 1'b1;
            rd_next    = S_ARREADY ? RD_DATA : RD_ADDR;
          end
        end
        RD_ADDR: begin
          S_ARVALID  = 1'b1;
          M0_ARREADY = (rd_owner == MST_M0) & S_ARREADY;
          M1_ARREADY = (rd_owner == MST_M1) & S_ARREADY;
          if (S_ARREADY) rd_next = RD_DATA;
        end
        RD_DATA: begin
          M0_RVALID = (rd_owner == MST_M0) & S_RVALID;
          M1_RVALID = (rd_owner == MST_M1) & S_RVALID;
          S_RREADY  = rd_owner ? M1_RREADY : M0_RREADY;
          if (S_RVALID && S_RREADY && S_RLAST) begin
            rd_next = RD_IDLE;
            rd_upd  = 1'b1;
          end
        end
        default: rd_next = RD_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_next = wr_state;  wr_latch = 1'b0;  wr_upd = 1'b0;  aw_src = wr_owner;
    S_AWVALID = 1'b0;  M0_AWREADY = 1'b0;  M1_AWREADY = 1'b0;
    S_WVALID  = 1'b0;  M0_WREADY  = 1'b0;  M1_WREADY  = 1'b0;
    S_BREADY  = 1'b0;  M0_BVALID  = 1'b0;  M1_BVALID  = 1'b0;
    if (!rst) begin
      case (wr_state)
        WR_IDLE: begin
          aw_src = wr_gnt[1];
          if (|wr_gnt) begin
            S_AWVALID  = 1'b1;
            M0_AWREADY = wr_gnt[0] & S_AWREADY;
            M1_AWREADY = wr_gnt[1] & S_AWREADY;
            wr_latch   = 1'b1;
            wr_next    = S_AWREADY ? WR_DATA : WR_ADDR;
          end
        end
        WR_ADDR: begin
          S_AWVALID  = 1'b1;
          M0_AWREADY = (wr_owner == MST_M0) & S_AWREADY;
          M1_AWREADY = (wr_owner == MST_M1) & S_AWREADY;
          if (S_AWREADY) wr_next = WR_DATA;
        end
        WR_DATA: begin
          S_WVALID  = wr_owner ? M1_WVALID : M0_WVALID;
          M0_WREADY = (wr_owner == MST_M0) & S_WREADY;
          M1_WREADY = (wr_owner == MST_M1) & S_WREADY;
          if (S_WVALID && S_WREADY && S_WLAST) wr_next = WR_RESP;
        end
        WR_RESP: begin
          M0_BVALID = (wr_owner == MST_M0) & S_BVALID;
          M1_BVALID = (wr_owner == MST_M1) & S_BVALID;
          S_BREADY  = wr_owner ? M1_BREADY : M0_BREADY;
          if (S_BVALID && S_BREADY) begin
            wr_next = WR_IDLE;
            wr_upd  = 1'b1;
          end
        end
        default: wr_next = WR_IDLE;
      endcase
    end
  end

endmodule
